core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Arbitrates a core's instruction-fetch and data ports onto one external word bus.
// Instruction fetches are two bus words (low then high); data accesses win ties.
module core_mem_arbiter #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     i_fetch_addr,
  input  logic              i_fetch_req,
  output logic [I_SIZE-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic [RW-1:0]     i_data_addr,
  input  logic [RW-1:0]     i_data_wdata,
  input  logic              i_data_req,
  input  logic              i_data_we,
  output logic [RW-1:0]     o_data_rdata,
  output logic              o_data_ack,
  output logic [RW:0]       o_bus_addr,
  output logic [RW-1:0]     o_bus_wdata,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic              o_bus_iside,
  input  logic [RW-1:0]     i_bus_rdata,
  input  logic              i_bus_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_I_LO  = 2'd1;
  localparam logic [1:0] S_I_HI  = 2'd2;
  localparam logic [1:0] S_D_ACC = 2'd3;

  logic [1:0]        state_q,       state_d;
  logic              pend_q,        pend_d;
  logic [RW-1:0]     fetch_addr_q,  fetch_addr_d;
  logic [RW-1:0]     cur_addr_q,    cur_addr_d;
  logic              stale_q,       stale_d;
  logic [RW-1:0]     dat_addr_q,    dat_addr_d;
  logic [RW-1:0]     dat_wdata_q,   dat_wdata_d;
  logic              dat_we_q,      dat_we_d;
  logic [I_SIZE-1:0] fetch_data_q,  fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [RW-1:0]     rdata_q,       rdata_d;
  logic              ack_q,         ack_d;

  logic [RW-1:0]     next_fetch_addr;
  logic              restart;

  // A fetch request arriving this cycle supersedes whatever address is already held.
  assign next_fetch_addr = i_fetch_req ? i_fetch_addr : fetch_addr_q;
  assign restart         = stale_q || i_fetch_req;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    pend_d        = pend_q;
    fetch_addr_d  = fetch_addr_q;
    cur_addr_d    = cur_addr_q;
    stale_d       = stale_q;
    dat_addr_d    = dat_addr_q;
    dat_wdata_d   = dat_wdata_q;
    dat_we_d      = dat_we_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    rdata_d       = rdata_q;
    ack_d         = 1'b0;

    if (i_fetch_req) begin
      pend_d       = 1'b1;
      fetch_addr_d = i_fetch_addr;
    end

    case (state_q)
      S_IDLE: begin
        // While the ack pulse is out the requester has not yet dropped its level request.
        if (i_data_req && !ack_q) begin
          state_d     = S_D_ACC;
          dat_addr_d  = i_data_addr;
          dat_wdata_d = i_data_wdata;
          dat_we_d    = i_data_we;
        end else if (pend_q || i_fetch_req) begin
          state_d    = S_I_LO;
          cur_addr_d = next_fetch_addr;
          stale_d    = 1'b0;
        end
      end

      S_I_LO: begin
        if (i_fetch_req) stale_d = 1'b1;
        if (i_bus_ack) begin
          if (restart) begin
            cur_addr_d = next_fetch_addr;
            stale_d    = 1'b0;
          end else begin
            fetch_data_d[RW-1:0] = i_bus_rdata;
            state_d              = S_I_HI;
          end
        end
      end

      S_I_HI: begin
        if (i_fetch_req) stale_d = 1'b1;
        if (i_bus_ack) begin
          if (restart) begin
            state_d    = S_I_LO;
            cur_addr_d = next_fetch_addr;
            stale_d    = 1'b0;
          end else begin
            fetch_data_d[I_SIZE-1:RW] = i_bus_rdata;
            fetch_valid_d             = 1'b1;
            pend_d                    = 1'b0;
            state_d                   = S_IDLE;
          end
        end
      end

      S_D_ACC: begin
        if (i_bus_ack) begin
          rdata_d = i_bus_rdata;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (i_rst) begin
      state_q       <= S_IDLE;
      pend_q        <= 1'b0;
      fetch_addr_q  <= '0;
      cur_addr_q    <= '0;
      stale_q       <= 1'b0;
      dat_addr_q    <= '0;
      dat_wdata_q   <= '0;
      dat_we_q      <= 1'b0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      fetch_addr_q  <= fetch_addr_d;
      cur_addr_q    <= cur_addr_d;
      stale_q       <= stale_d;
      dat_addr_q    <= dat_addr_d;
      dat_wdata_q   <= dat_wdata_d;
      dat_we_q      <= dat_we_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      rdata_q       <= rdata_d;
      ack_q         <= ack_d;
    end
  end

  // Bus side is decoded purely from registered state, so it cannot move while a word waits for ack.
  always_comb begin
    o_bus_req   = 1'b0;
    o_bus_iside = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    case (state_q)
      S_I_LO: begin
        o_bus_req   = 1'b1;
        o_bus_iside = 1'b1;
        o_bus_addr  = {cur_addr_q, 1'b0};
      end
      S_I_HI: begin
        o_bus_req   = 1'b1;
        o_bus_iside = 1'b1;
        o_bus_addr  = {cur_addr_q, 1'b1};
      end
      S_D_ACC: begin
        o_bus_req   = 1'b1;
        o_bus_we    = dat_we_q;
        o_bus_addr  = {1'b0, dat_addr_q};
        o_bus_wdata = dat_wdata_q;
      end
      default: ;
    endcase
  end

  assign o_fetch_data  = fetch_data_q;
  assign o_fetch_valid = fetch_valid_q;
  assign o_data_rdata  = rdata_q;
  assign o_data_ack    = ack_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a bus responder with programmable wait states
// feeds queued read words; each scenario task steps cycles and compares outputs inline.
module tb_core_mem_arbiter;
  localparam int RW     = 16;
  localparam int I_SIZE = 32;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [RW-1:0]     i_fetch_addr = '0;
  logic              i_fetch_req = 1'b0;
  logic [I_SIZE-1:0] o_fetch_data;
  logic              o_fetch_valid;
  logic [RW-1:0]     i_data_addr = '0;
  logic [RW-1:0]     i_data_wdata = '0;
  logic              i_data_req = 1'b0;
  logic              i_data_we = 1'b0;
  logic [RW-1:0]     o_data_rdata;
  logic              o_data_ack;
  logic [RW:0]       o_bus_addr;
  logic [RW-1:0]     o_bus_wdata;
  logic              o_bus_req;
  logic              o_bus_we;
  logic              o_bus_iside;
  logic [RW-1:0]     i_bus_rdata = '0;
  logic              i_bus_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int            bus_wait    = 0;
  bit            bus_auto    = 1'b1;
  logic          force_ack   = 1'b0;
  logic [RW-1:0] force_rdata = '0;
  logic [RW-1:0] rq[$];
  int            wait_cnt    = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.RW(RW), .I_SIZE(I_SIZE)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_fetch_addr (i_fetch_addr),
    .i_fetch_req  (i_fetch_req),
    .o_fetch_data (o_fetch_data),
    .o_fetch_valid(o_fetch_valid),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .i_data_req   (i_data_req),
    .i_data_we    (i_data_we),
    .o_data_rdata (o_data_rdata),
    .o_data_ack   (o_data_ack),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_iside  (o_bus_iside),
    .i_bus_rdata  (i_bus_rdata),
    .i_bus_ack    (i_bus_ack)
  );

  // Bus slave: acks after bus_wait idle cycles of a held request, popping read data from rq.
  always @(negedge clk) begin
    if (!bus_auto) begin
      i_bus_ack   = force_ack;
      i_bus_rdata = force_rdata;
    end else if (o_bus_req) begin
      if (wait_cnt >= bus_wait) begin
        i_bus_ack = 1'b1;
        if (rq.size() > 0) i_bus_rdata = rq.pop_front();
        else               i_bus_rdata = '0;
        wait_cnt = 0;
      end else begin
        i_bus_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      i_bus_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_fetch_req = 1'b1;
    i_fetch_addr = 16'h0123;
    cyc();
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_we, o_bus_iside, o_fetch_valid, o_data_ack,
         o_fetch_data, o_data_rdata, o_bus_addr, o_bus_wdata} !== 86'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b iside=%b fv=%b ack=%b fd=%h rd=%h addr=%h wd=%h want all zero",
               o_bus_req, o_bus_we, o_bus_iside, o_fetch_valid, o_data_ack,
               o_fetch_data, o_data_rdata, o_bus_addr, o_bus_wdata);
    end
    i_rst       = 1'b0;
    i_fetch_req = 1'b0;
    cyc();
    n_checks++;
    if (o_bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pending: got bus_req=%b want 0", o_bus_req);
    end
  endtask

  task automatic test_fetch_basic();
    bus_wait = 0;
    rq = '{16'hBEEF, 16'h1234};
    i_fetch_addr = 16'h0040;
    i_fetch_req  = 1'b1;
    cyc();
    i_fetch_req = 1'b0;
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_we, o_bus_addr} !== {3'b110, 17'h00080}) begin
      n_fail++;
      $display("FAIL fetch_lo_bus: got req/iside/we=%b%b%b addr=%h want 110 00080",
               o_bus_req, o_bus_iside, o_bus_we, o_bus_addr);
    end
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_we, o_bus_addr, o_fetch_valid} !== {3'b110, 17'h00081, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_hi_bus: got req/iside/we=%b%b%b addr=%h fv=%b want 110 00081 0",
               o_bus_req, o_bus_iside, o_bus_we, o_bus_addr, o_fetch_valid);
    end
    cyc();
    n_checks++;
    if ({o_fetch_valid, o_fetch_data, o_bus_req} !== {1'b1, 32'h1234BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_result: got fv=%b data=%h req=%b want 1 1234beef 0",
               o_fetch_valid, o_fetch_data, o_bus_req);
    end
    cyc();
    n_checks++;
    if (o_fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_valid_pulse: got fv=%b want 0", o_fetch_valid);
    end
  endtask

  task automatic test_data_priority();
    bus_wait = 0;
    rq = '{16'h5A5A, 16'h0A0B, 16'h0C0D};
    i_fetch_addr = 16'h0010;
    i_fetch_req  = 1'b1;
    i_data_addr  = 16'h0200;
    i_data_we    = 1'b0;
    i_data_req   = 1'b1;
    cyc();
    i_fetch_req = 1'b0;
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_we, o_bus_addr} !== {3'b100, 17'h00200}) begin
      n_fail++;
      $display("FAIL prio_data_first: got req/iside/we=%b%b%b addr=%h want 100 00200",
               o_bus_req, o_bus_iside, o_bus_we, o_bus_addr);
    end
    cyc();
    n_checks++;
    if ({o_data_ack, o_data_rdata, o_bus_req} !== {1'b1, 16'h5A5A, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_data_ack: got ack=%b rdata=%h req=%b want 1 5a5a 0",
               o_data_ack, o_data_rdata, o_bus_req);
    end
    i_data_req = 1'b0;
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_addr, o_data_ack} !== {2'b11, 17'h00020, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_fetch_lo: got req/iside=%b%b addr=%h ack=%b want 11 00020 0",
               o_bus_req, o_bus_iside, o_bus_addr, o_data_ack);
    end
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_addr} !== {2'b11, 17'h00021}) begin
      n_fail++;
      $display("FAIL prio_fetch_hi: got req/iside=%b%b addr=%h want 11 00021",
               o_bus_req, o_bus_iside, o_bus_addr);
    end
    cyc();
    n_checks++;
    if ({o_fetch_valid, o_fetch_data} !== {1'b1, 32'h0C0D0A0B}) begin
      n_fail++;
      $display("FAIL prio_fetch_done: got fv=%b data=%h want 1 0c0d0a0b", o_fetch_valid, o_fetch_data);
    end
    cyc();
  endtask

  task automatic test_data_write_wait();
    int ack_cnt;
    ack_cnt      = 0;
    bus_wait     = 3;
    i_data_addr  = 16'h0005;
    i_data_wdata = 16'hAAAA;
    i_data_we    = 1'b1;
    i_data_req   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_checks++;
      if ({o_bus_req, o_bus_iside, o_bus_we, o_bus_addr, o_bus_wdata, o_data_ack} !==
          {3'b101, 17'h00005, 16'hAAAA, 1'b0}) begin
        n_fail++;
        $display("FAIL write_stable_c%0d: got req/iside/we=%b%b%b addr=%h wdata=%h ack=%b want 101 00005 aaaa 0",
                 k, o_bus_req, o_bus_iside, o_bus_we, o_bus_addr, o_bus_wdata, o_data_ack);
      end
    end
    cyc();
    ack_cnt += int'(o_data_ack);
    n_checks++;
    if ({o_data_ack, o_bus_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_ack: got ack=%b req=%b want 1 0", o_data_ack, o_bus_req);
    end
    cyc();
    ack_cnt += int'(o_data_ack);
    n_checks++;
    if (o_bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_regrant: got bus_req=%b want 0", o_bus_req);
    end
    i_data_req = 1'b0;
    i_data_we  = 1'b0;
    cyc();
    ack_cnt += int'(o_data_ack);
    n_checks++;
    if (ack_cnt !== 1) begin
      n_fail++;
      $display("FAIL write_single_ack: got %0d ack pulses want 1", ack_cnt);
    end
  endtask

  task automatic test_fetch_restart_lo();
    int fv_cnt;
    fv_cnt   = 0;
    bus_wait = 1;
    rq = '{16'h1111, 16'h2222, 16'h3333};
    i_fetch_addr = 16'h0030;
    i_fetch_req  = 1'b1;
    cyc();
    n_checks++;
    if (o_bus_addr !== 17'h00060) begin
      n_fail++;
      $display("FAIL restart_lo_first: got addr=%h want 00060", o_bus_addr);
    end
    i_fetch_addr = 16'h0031;
    cyc();
    i_fetch_req = 1'b0;
    n_checks++;
    if (o_bus_addr !== 17'h00060) begin
      n_fail++;
      $display("FAIL restart_lo_stable: got addr=%h want 00060", o_bus_addr);
    end
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 17'h00062}) begin
      n_fail++;
      $display("FAIL restart_lo_new: got req=%b addr=%h want 1 00062", o_bus_req, o_bus_addr);
    end
    for (int k = 4; k <= 8; k++) begin
      cyc();
      fv_cnt += int'(o_fetch_valid);
      if (k == 7) begin
        n_checks++;
        if ({o_fetch_valid, o_fetch_data} !== {1'b1, 32'h33332222}) begin
          n_fail++;
          $display("FAIL restart_lo_done: got fv=%b data=%h want 1 33332222", o_fetch_valid, o_fetch_data);
        end
      end
    end
    n_checks++;
    if (fv_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_lo_one_valid: got %0d valid pulses want 1", fv_cnt);
    end
  endtask

  task automatic test_fetch_restart_hi();
    int fv_cnt;
    fv_cnt   = 0;
    bus_wait = 0;
    rq = '{16'hAAA1, 16'hAAA2, 16'h1357, 16'h2468};
    i_fetch_addr = 16'h0100;
    i_fetch_req  = 1'b1;
    cyc();
    i_fetch_req = 1'b0;
    n_checks++;
    if (o_bus_addr !== 17'h00200) begin
      n_fail++;
      $display("FAIL restart_hi_lo_addr: got addr=%h want 00200", o_bus_addr);
    end
    cyc();
    fv_cnt += int'(o_fetch_valid);
    n_checks++;
    if (o_bus_addr !== 17'h00201) begin
      n_fail++;
      $display("FAIL restart_hi_hi_addr: got addr=%h want 00201", o_bus_addr);
    end
    i_fetch_addr = 16'h0200;
    i_fetch_req  = 1'b1;
    cyc();
    i_fetch_req = 1'b0;
    fv_cnt += int'(o_fetch_valid);
    n_checks++;
    if ({o_fetch_valid, o_bus_req, o_bus_iside, o_bus_addr} !== {3'b011, 17'h00400}) begin
      n_fail++;
      $display("FAIL restart_hi_new_lo: got fv=%b req/iside=%b%b addr=%h want 0 11 00400",
               o_fetch_valid, o_bus_req, o_bus_iside, o_bus_addr);
    end
    cyc();
    fv_cnt += int'(o_fetch_valid);
    n_checks++;
    if (o_bus_addr !== 17'h00401) begin
      n_fail++;
      $display("FAIL restart_hi_new_hi: got addr=%h want 00401", o_bus_addr);
    end
    cyc();
    fv_cnt += int'(o_fetch_valid);
    n_checks++;
    if ({o_fetch_valid, o_fetch_data} !== {1'b1, 32'h24681357}) begin
      n_fail++;
      $display("FAIL restart_hi_done: got fv=%b data=%h want 1 24681357", o_fetch_valid, o_fetch_data);
    end
    cyc();
    fv_cnt += int'(o_fetch_valid);
    n_checks++;
    if (fv_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_hi_one_valid: got %0d valid pulses want 1", fv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus_auto    = 1'b0;
    force_ack   = 1'b0;
    i_data_addr = 16'h0077;
    i_data_we   = 1'b0;
    i_data_req  = 1'b1;
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_iside, o_bus_addr} !== {2'b10, 17'h00077}) begin
      n_fail++;
      $display("FAIL rstmid_in_dacc: got req/iside=%b%b addr=%h want 10 00077",
               o_bus_req, o_bus_iside, o_bus_addr);
    end
    force_ack   = 1'b1;
    force_rdata = 16'hFFFF;
    i_rst       = 1'b1;
    cyc();
    n_checks++;
    if ({o_bus_req, o_bus_we, o_bus_iside, o_fetch_valid, o_data_ack,
         o_fetch_data, o_data_rdata, o_bus_addr, o_bus_wdata} !== 86'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%b we=%b iside=%b fv=%b ack=%b fd=%h rd=%h addr=%h wd=%h want all zero",
               o_bus_req, o_bus_we, o_bus_iside, o_fetch_valid, o_data_ack,
               o_fetch_data, o_data_rdata, o_bus_addr, o_bus_wdata);
    end
    i_rst      = 1'b0;
    i_data_req = 1'b0;
    force_ack  = 1'b0;
    cyc();
    n_checks++;
    if ({o_data_ack, o_bus_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_idle: got ack=%b req=%b want 0 0", o_data_ack, o_bus_req);
    end
    bus_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_data_priority();
    test_data_write_wait();
    test_fetch_restart_lo();
    test_fetch_restart_hi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
